// File: rtl/sp_arbiter.sv
// Arbitrates between a result-matrix writer and a bus reader for one scratchpad port.
// Round-robin on contention; out-of-range requests are answered with an error pulse.
module sp_arbiter #(
    parameter  int SP_NTARGETS = 4,
    parameter  int DATA_WIDTH  = 32,
    parameter  int BUS_WIDTH   = 64,
    parameter  int ADDR_WIDTH  = 32,
    localparam int MAX_DIM     = BUS_WIDTH / DATA_WIDTH,
    localparam int DEPTH       = SP_NTARGETS * MAX_DIM * MAX_DIM,
    localparam int SPN_W       = $clog2(MAX_DIM) + 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    wr_req_i,
    input  logic [SPN_W-1:0]        wr_sp_i,
    output logic                    wr_ack_o,
    input  logic                    rd_req_i,
    input  logic [ADDR_WIDTH-1:0]   rd_addr_i,
    output logic                    rd_valid_o,
    output logic [2*DATA_WIDTH-1:0] rd_data_o,
    output logic                    err_o,
    output logic                    sp_we_o,
    output logic [SPN_W-1:0]        sp_number_o,
    output logic [ADDR_WIDTH-1:0]   sp_address_o,
    input  logic [2*DATA_WIDTH-1:0] sp_data_i,
    output logic                    busy_o
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

    state_t                  state_q, state_d;
    logic                    rd_prio_q, rd_prio_d;
    logic [SPN_W-1:0]        wr_sp_q;
    logic [ADDR_WIDTH-1:0]   rd_addr_q;
    logic                    wr_rej_q;
    logic                    rd_err_q;
    logic [2*DATA_WIDTH-1:0] rd_data_q;
    logic                    grant_wr, grant_rd, wr_bad, rd_bad;

    assign wr_bad = 32'(wr_sp_i) >= SP_NTARGETS;
    assign rd_bad = rd_addr_i >= ADDR_WIDTH'(DEPTH);

    // A rejected write borrows the RESP cycle (flagged by wr_rej_q) so the
    // requester sees its ack one cycle after sampling, just like a real write.
    always_comb begin
        state_d   = state_q;
        rd_prio_d = rd_prio_q;
        grant_wr  = 1'b0;
        grant_rd  = 1'b0;
        case (state_q)
            IDLE: begin
                grant_wr = wr_req_i && (!rd_req_i || !rd_prio_q);
                grant_rd = rd_req_i && !grant_wr;
                if (grant_wr) begin
                    state_d   = wr_bad ? RESP : WRITE;
                    rd_prio_d = 1'b1;
                end else if (grant_rd) begin
                    state_d   = rd_bad ? RESP : READ;
                    rd_prio_d = 1'b0;
                end
            end
            WRITE:   state_d = IDLE;
            READ:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            rd_prio_q <= 1'b0;
            wr_sp_q   <= '0;
            rd_addr_q <= '0;
            wr_rej_q  <= 1'b0;
            rd_err_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_prio_q <= rd_prio_d;
            if (grant_wr) begin
                wr_sp_q  <= wr_sp_i;
                wr_rej_q <= wr_bad;
                rd_err_q <= 1'b0;
            end
            if (grant_rd) begin
                rd_addr_q <= rd_addr_i;
                rd_err_q  <= rd_bad;
                wr_rej_q  <= 1'b0;
                if (rd_bad)
                    rd_data_q <= '0;
            end
            if (state_q == READ)
                rd_data_q <= sp_data_i;
        end
    end

    always_comb begin
        sp_we_o      = (state_q == WRITE);
        sp_number_o  = (state_q == WRITE) ? wr_sp_q : '0;
        sp_address_o = (state_q == READ) ? rd_addr_q : '0;
        wr_ack_o     = (state_q == WRITE) || (state_q == RESP && wr_rej_q);
        rd_valid_o   = (state_q == RESP) && !wr_rej_q;
        err_o        = (state_q == RESP) && (wr_rej_q || rd_err_q);
        busy_o       = (state_q != IDLE);
        rd_data_o    = rd_data_q;
    end

endmodule
